// File: rtl/spi_axi_phy.sv
// SPI mode-0 slave front-end: pin synchronizers, SCK edge detect, MSB-first
// byte deserializer with valid strobe, and MISO serializer fed by the controller.
module spi_axi_phy #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_t,
  output logic       spi_rx_ss,
  output logic       spi_rx_first,
  output logic [7:0] spi_rx_byte,
  output logic [2:0] spi_rx_bitcnt,
  output logic       spi_rx_valid,
  input  logic [7:0] spi_tx_data,
  output logic       spi_tx_load
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync, fill_sync;
  logic                   sck_prev;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise, sck_fall;
  logic                   armed;
  logic                   enter, leave, active_stay;

  logic [2:0] bitcnt;
  logic       first_flag;
  logic       byte_done;
  logic [7:0] rx_shift;
  logic [6:0] tx_shift;

  // Stage: pin synchronizers; fill_sync marks when the preset values have flushed
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      fill_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      fill_sync <= {fill_sync[SYNC_STAGES-2:0], 1'b1};
      sck_prev  <= sck_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;

  // A select is only honoured after a genuine deselect has been observed, so a
  // reset in the middle of a frame cannot resume on a half-finished transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (fill_sync[SYNC_STAGES-1] && ss_s) begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    enter       = 1'b0;
    leave       = 1'b0;
    active_stay = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed && !ss_s) begin
          state_d = ACTIVE;
          enter   = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_s) begin
          state_d = IDLE;
          leave   = 1'b1;
        end else begin
          active_stay = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage: shift registers (data only)
  always_ff @(posedge clk) begin
    if (active_stay && sck_rise) begin
      rx_shift <= {rx_shift[6:0], mosi_s};
    end
    if (enter) begin
      tx_shift <= spi_tx_data[6:0];
    end else if (active_stay && sck_fall) begin
      tx_shift <= (bitcnt == 3'd0) ? spi_tx_data[6:0] : {tx_shift[5:0], 1'b0};
    end
  end

  // Stage: bit counting, byte strobe and MISO drive
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt       <= 3'd0;
      first_flag   <= 1'b0;
      byte_done    <= 1'b0;
      spi_rx_valid <= 1'b0;
      spi_rx_byte  <= 8'h00;
      spi_rx_first <= 1'b0;
      spi_tx_load  <= 1'b0;
      spi_miso     <= 1'b0;
      spi_miso_t   <= 1'b1;
      spi_rx_ss    <= 1'b1;
    end else begin
      spi_rx_valid <= 1'b0;
      spi_tx_load  <= 1'b0;
      byte_done    <= 1'b0;
      spi_rx_ss    <= (state_d == IDLE);

      if (byte_done) begin
        spi_rx_valid <= 1'b1;
        spi_rx_byte  <= rx_shift;
        spi_rx_first <= first_flag;
        first_flag   <= 1'b0;
      end

      if (enter) begin
        bitcnt      <= 3'd0;
        first_flag  <= 1'b1;
        spi_tx_load <= 1'b1;
        spi_miso    <= spi_tx_data[7];
        spi_miso_t  <= 1'b0;
      end else if (leave) begin
        bitcnt     <= 3'd0;
        spi_miso   <= 1'b0;
        spi_miso_t <= 1'b1;
      end else if (active_stay) begin
        if (sck_rise) begin
          bitcnt    <= bitcnt + 3'd1;
          byte_done <= (bitcnt == 3'd7);
        end
        // bitcnt of zero on a falling edge means the previous byte just completed
        if (sck_fall) begin
          if (bitcnt != 3'd0) begin
            spi_miso <= tx_shift[6];
          end else begin
            spi_tx_load <= 1'b1;
            spi_miso    <= spi_tx_data[7];
          end
        end
      end
    end
  end

  assign spi_rx_bitcnt = bitcnt;

endmodule

// File: tb/tb_spi_axi_phy.sv
// Directed bench for spi_axi_phy: bit-banged SPI master, event monitor and
// hand-computed expected bytes, strobes and MISO patterns.
module tb_spi_axi_phy;
  localparam int SS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_ss_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [7:0] spi_tx_data = 8'h00;
  logic       spi_miso, spi_miso_t, spi_rx_ss, spi_rx_first, spi_rx_valid, spi_tx_load;
  logic [7:0] spi_rx_byte;
  logic [2:0] spi_rx_bitcnt;

  always #5 clk = ~clk;

  spi_axi_phy #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_t(spi_miso_t), .spi_rx_ss(spi_rx_ss),
    .spi_rx_first(spi_rx_first), .spi_rx_byte(spi_rx_byte), .spi_rx_bitcnt(spi_rx_bitcnt),
    .spi_rx_valid(spi_rx_valid), .spi_tx_data(spi_tx_data), .spi_tx_load(spi_tx_load)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int overlap = 0;
  logic [7:0] rxb_q[$];
  logic       rxf_q[$];
  logic [2:0] rxn_q[$];
  int         rxc_q[$];
  int         ld_q[$];

  logic [7:0] tx_tab[17];
  int tx_i = 17;
  int rx_base = 0;
  int ld_base = 0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (spi_rx_valid) begin
      rxb_q.push_back(spi_rx_byte);
      rxf_q.push_back(spi_rx_first);
      rxn_q.push_back(spi_rx_bitcnt);
      rxc_q.push_back(cyc);
    end
    if (spi_tx_load) ld_q.push_back(cyc);
    if (spi_rx_valid && spi_tx_load) overlap = overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rxb(input int i);
    return (i < rxb_q.size()) ? rxb_q[i] : 8'hxx;
  endfunction
  function automatic logic rxf(input int i);
    return (i < rxf_q.size()) ? rxf_q[i] : 1'bx;
  endfunction
  function automatic logic [2:0] rxn(input int i);
    return (i < rxn_q.size()) ? rxn_q[i] : 3'bxxx;
  endfunction
  function automatic int rxc(input int i);
    return (i < rxc_q.size()) ? rxc_q[i] : -1;
  endfunction
  function automatic int ld_upto(input int from, input int upto);
    int n = 0;
    for (int i = from; i < ld_q.size(); i++) if (ld_q[i] <= upto) n++;
    return n;
  endfunction

  // Controller model: after each received byte, present the next TX byte.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (tx_i < 17 && (rxb_q.size() - rx_base) >= tx_i) begin
        spi_tx_data = tx_tab[tx_i];
        tx_i++;
      end
    end
  endtask

  task automatic begin_test();
    rx_base = rxb_q.size();
    ld_base = ld_q.size();
    tx_i = 1;
    spi_tx_data = tx_tab[0];
  endtask

  task automatic xfer(input int nbits, input logic [7:0] mo, input int lo, input int hi,
                      output logic [7:0] mi, output int rise_cyc);
    mi = 8'h00;
    rise_cyc = 0;
    for (int b = 0; b < nbits; b++) begin
      spi_mosi = mo[7-b];
      tick(lo);
      spi_sck = 1'b1;
      rise_cyc = cyc;
      tick(hi);
      mi = {mi[6:0], spi_miso};
      spi_sck = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] mi;
    logic [7:0] mis[16];
    logic [7:0] rxv[16];
    int rc;

    tx_tab = '{default: 8'h00};
    tick(3);
    rst = 1'b0;
    chk("rst_ss", spi_rx_ss, 1'b1);
    chk("rst_miso_t", spi_miso_t, 1'b1);
    chk("rst_miso", spi_miso, 1'b0);
    chk("rst_byte", spi_rx_byte, 8'h00);
    chk("rst_bitcnt", spi_rx_bitcnt, 3'd0);
    chk("rst_first", spi_rx_first, 1'b0);

    // 1: SCK activity with SS_N high
    tick(5);
    xfer(8, 8'hA5, 4, 4, mi, rc);
    xfer(8, 8'h3C, 4, 4, mi, rc);
    tick(10);
    chk("idle_nvalid", rxb_q.size(), 0);
    chk("idle_nload", ld_q.size(), 0);
    chk("idle_ss", spi_rx_ss, 1'b1);
    chk("idle_miso_t", spi_miso_t, 1'b1);

    // 2: single byte A5, TX 3C
    tx_tab = '{default: 8'h00};
    tx_tab[0] = 8'h3C;
    begin_test();
    spi_ss_n = 1'b0;
    tick(6);
    chk("t2_active_ss", spi_rx_ss, 1'b0);
    chk("t2_active_miso_t", spi_miso_t, 1'b0);
    xfer(8, 8'hA5, 4, 4, mi, rc);
    tick(6);
    spi_ss_n = 1'b1;
    tick(10);
    chk("t2_nvalid", rxb_q.size() - rx_base, 1);
    chk("t2_byte", rxb(rx_base), 8'hA5);
    chk("t2_first", rxf(rx_base), 1'b1);
    chk("t2_bitcnt_at_valid", rxn(rx_base), 3'd0);
    chk("t2_latency", rxc(rx_base) - rc, SS + 2);
    chk("t2_entry_load", ld_upto(ld_base, rxc(rx_base)), 1);
    chk("t2_miso", mi, 8'h3C);
    chk("t2_end_ss", spi_rx_ss, 1'b1);
    chk("t2_end_miso_t", spi_miso_t, 1'b1);
    chk("t2_end_miso", spi_miso, 1'b0);

    // 3: burst 81/02/FF, TX 3C then C3 then 99
    tx_tab = '{default: 8'h00};
    tx_tab[0] = 8'h3C; tx_tab[1] = 8'hC3; tx_tab[2] = 8'h99;
    begin_test();
    spi_ss_n = 1'b0;
    tick(6);
    xfer(8, 8'h81, 4, 4, mis[0], rc);
    xfer(8, 8'h02, 4, 4, mis[1], rc);
    xfer(8, 8'hFF, 4, 4, mis[2], rc);
    tick(6);
    spi_ss_n = 1'b1;
    tick(10);
    chk("t3_nvalid", rxb_q.size() - rx_base, 3);
    chk("t3_byte0", rxb(rx_base), 8'h81);
    chk("t3_byte1", rxb(rx_base + 1), 8'h02);
    chk("t3_byte2", rxb(rx_base + 2), 8'hFF);
    chk("t3_first0", rxf(rx_base), 1'b1);
    chk("t3_first1", rxf(rx_base + 1), 1'b0);
    chk("t3_first2", rxf(rx_base + 2), 1'b0);
    chk("t3_miso0", mis[0], 8'h3C);
    chk("t3_miso1", mis[1], 8'hC3);
    chk("t3_miso2", mis[2], 8'h99);
    chk("t3_nload", ld_upto(ld_base, rxc(rx_base + 2)), 3);

    // 4: aborted byte after 5 bits, then a fresh select with 5A
    tx_tab = '{default: 8'h00};
    tx_tab[0] = 8'hE7;
    begin_test();
    spi_ss_n = 1'b0;
    tick(6);
    xfer(5, 8'hB6, 4, 4, mi, rc);
    tick(6);
    chk("t4_partial_bitcnt", spi_rx_bitcnt, 3'd5);
    spi_ss_n = 1'b1;
    tick(10);
    chk("t4_partial_nvalid", rxb_q.size() - rx_base, 0);
    chk("t4_byte_held", spi_rx_byte, 8'hFF);
    chk("t4_gap_miso_t", spi_miso_t, 1'b1);
    chk("t4_gap_bitcnt", spi_rx_bitcnt, 3'd0);
    begin_test();
    spi_ss_n = 1'b0;
    tick(6);
    xfer(8, 8'h5A, 4, 4, mi, rc);
    tick(6);
    spi_ss_n = 1'b1;
    tick(10);
    chk("t4_nvalid", rxb_q.size() - rx_base, 1);
    chk("t4_byte", rxb(rx_base), 8'h5A);
    chk("t4_first", rxf(rx_base), 1'b1);
    chk("t4_miso", mi, 8'hE7);

    // 5: reset after 4 bits of F0 with SS_N held low
    tx_tab = '{default: 8'h00};
    tx_tab[0] = 8'h0F;
    begin_test();
    spi_ss_n = 1'b0;
    tick(6);
    xfer(4, 8'hF0, 4, 4, mi, rc);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_rst_ss", spi_rx_ss, 1'b1);
    chk("t5_rst_miso_t", spi_miso_t, 1'b1);
    chk("t5_rst_miso", spi_miso, 1'b0);
    chk("t5_rst_byte", spi_rx_byte, 8'h00);
    chk("t5_rst_bitcnt", spi_rx_bitcnt, 3'd0);
    tick(6);
    xfer(8, 8'h33, 4, 4, mi, rc);
    tick(6);
    chk("t5_locked_nvalid", rxb_q.size() - rx_base, 0);
    chk("t5_locked_ss", spi_rx_ss, 1'b1);
    chk("t5_locked_miso_t", spi_miso_t, 1'b1);
    spi_ss_n = 1'b1;
    tick(10);
    begin_test();
    spi_ss_n = 1'b0;
    tick(6);
    xfer(8, 8'hF0, 4, 4, mi, rc);
    tick(6);
    spi_ss_n = 1'b1;
    tick(10);
    chk("t5_nvalid", rxb_q.size() - rx_base, 1);
    chk("t5_byte", rxb(rx_base), 8'hF0);
    chk("t5_first", rxf(rx_base), 1'b1);
    chk("t5_miso", mi, 8'h0F);

    // 6: minimum timing, 16 random bytes each way
    for (int i = 0; i < 17; i++) tx_tab[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) rxv[i] = 8'($urandom_range(0, 255));
    begin_test();
    spi_ss_n = 1'b0;
    for (int i = 0; i < 16; i++) xfer(8, rxv[i], 3, 3, mis[i], rc);
    tick(3);
    spi_ss_n = 1'b1;
    tick(10);
    chk("t6_nvalid", rxb_q.size() - rx_base, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t6_byte%0d", i), rxb(rx_base + i), rxv[i]);
      chk($sformatf("t6_miso%0d", i), mis[i], tx_tab[i]);
      chk($sformatf("t6_first%0d", i), rxf(rx_base + i), (i == 0) ? 1'b1 : 1'b0);
    end

    chk("valid_load_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_axi_phy.md
Name: spi_axi_phy

Overview:
SPI slave front-end that sits directly upstream of the SPI-to-AXI control FSM, in the system clock domain. It synchronizes the raw SPI pins (SCK, SS_N, MOSI) and detects SCK edges. It deserializes MOSI into bytes that are handed to the controller with a per-byte valid strobe, and serializes controller-supplied bytes onto MISO. Only SPI mode 0 (CPOL=0, CPHA=0), MSB first, is supported.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizers on spi_sck, spi_ss_n and spi_mosi (minimum 2; all three use the same depth).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
spi_sck  in  1  SPI clock pin, asynchronous
spi_ss_n  in  1  SPI slave select pin, active-low, asynchronous
spi_mosi  in  1  SPI data in, asynchronous
spi_miso  out  1  SPI data out
spi_miso_t  out  1  MISO tristate enable (1 = hi-Z)
spi_rx_ss  out  1  synchronized deselect (1 = SS_N high / idle)
spi_rx_first  out  1  qualifies spi_rx_valid: the byte is the first byte since SS_N asserted
spi_rx_byte  out  8  last completed received byte, MSB first
spi_rx_bitcnt  out  3  bits received so far in the current byte (0..7)
spi_rx_valid  out  1  one-cycle strobe: spi_rx_byte holds a new complete byte
spi_tx_data  in  8  next byte to transmit, driven by the controller
spi_tx_load  out  1  one-cycle strobe: spi_tx_data was captured into the TX shifter this cycle

Behaviour:
- Reset (rst=1 at posedge clk): spi_rx_ss=1, spi_rx_first=0, spi_rx_byte=8'h00, spi_rx_bitcnt=0, spi_rx_valid=0, spi_tx_load=0, spi_miso=0, spi_miso_t=1. Synchronizer flops preset to SCK=0, SS_N=1, MOSI=0.
- Synchronization: all three pins pass through SYNC_STAGES flops. One further register gives the previous SCK for edge detection, so sck_rise and sck_fall are single-cycle pulses.
- Timing requirement: SCK high time and low time must each be at least 3 clk periods. SS_N setup to the first SCK rise and hold after the last SCK fall must each be at least 3 clk periods.
- States: IDLE and ACTIVE.
  - IDLE -> ACTIVE when synchronized SS_N goes low.
  - ACTIVE -> IDLE when synchronized SS_N goes high.
  - spi_rx_ss = 1 in IDLE, 0 in ACTIVE, and is registered.
- IDLE -> ACTIVE entry cycle:
  - bitcnt <= 0; first_flag <= 1.
  - spi_tx_data is loaded into the TX shifter; spi_tx_load=1 for that cycle.
  - spi_miso <= spi_tx_data[7]; spi_miso_t <= 0.
- RX (ACTIVE, on sck_rise):
  - Shift the synchronized MOSI into the RX shifter, MSB first; bitcnt increments.
  - At the 8th rise, bitcnt wraps 7->0. The next cycle spi_rx_byte is updated, spi_rx_valid=1 for exactly one cycle, and spi_rx_first=first_flag. first_flag clears after that strobe.
  - spi_rx_byte holds its value until the next complete byte.
  - spi_rx_bitcnt reads 0 on the valid cycle.
- RX latency: MOSI/SCK rising edge at the pins -> spi_rx_valid = SYNC_STAGES+2 clk cycles.
- TX (ACTIVE, on sck_fall):
  - If bitcnt != 0: shift the TX shifter left and drive spi_miso with the next bit.
  - If bitcnt == 0 (byte boundary, after the first byte's 8th rise): load spi_tx_data into the TX shifter, pulse spi_tx_load, and drive spi_miso <= spi_tx_data[7].
  - spi_tx_data is therefore sampled at least 1 cycle after spi_rx_valid, so the controller can update it combinationally from its next state.
- SS_N deasserted mid-byte:
  - The partial byte is discarded: no spi_rx_valid, bitcnt <= 0.
  - spi_miso_t <= 1 and spi_miso <= 0 the cycle IDLE is entered.
  - spi_rx_byte is unchanged.
- SCK edges while IDLE are ignored: no shifting, no strobes.
- SS_N re-assertion restarts at bit 0, with first_flag set again.
- spi_rx_valid and spi_tx_load can never be asserted in the same cycle (separated by the SCK high time).
- rst asserted mid-transfer: the block returns to its reset values immediately. It re-enters ACTIVE only after SS_N is seen high and then low again.

Test Plan:
1. Reset, then idle pins (SS_N=1, SCK toggling) -> spi_rx_valid never pulses, spi_rx_ss=1, spi_miso_t=1.
2. SS_N low, send 8'hA5, spi_tx_data=8'h3C held -> spi_tx_load pulses on SS entry. MISO bits on the 8 rises read 0,0,1,1,1,1,0,0. Single spi_rx_valid with spi_rx_byte=8'hA5 and spi_rx_first=1, SYNC_STAGES+2 cycles after the 8th SCK rise.
3. Three-byte burst 8'h81, 8'h02, 8'hFF; controller changes spi_tx_data to 8'hC3 after the first valid -> second byte's MISO = 8'hC3. Three valid strobes with first=1,0,0 and bytes 81/02/FF. spi_tx_load pulses 3 times (entry plus 2 boundaries).
4. SS_N high after 5 SCK rises, then a new select sending 8'h5A -> no valid for the partial byte; spi_rx_byte becomes 8'h5A with first=1; spi_miso_t=1 between selects.
5. rst pulsed after 4 bits of 8'hF0 while SS_N stays low -> outputs return to reset values; no valid until SS_N toggles high then low.
6. Minimum timing (SCK high/low = 3 clk, SYNC_STAGES=3): random 16-byte burst -> all bytes received correctly, and all MISO bits match the supplied spi_tx_data sequence.
